// File: rtl/lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_ctrl : single-outstanding load/store controller for a 32-bit bus |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  mem_oper_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  exc_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [4:0] EXC_NO_TRAP   = 5'b10000;
  localparam logic [4:0] EXC_ILL_INSTR = 5'd2;
  localparam logic [4:0] EXC_LD_MISAL  = 5'd4;
  localparam logic [4:0] EXC_LD_FAULT  = 5'd5;
  localparam logic [4:0] EXC_ST_MISAL  = 5'd6;
  localparam logic [4:0] EXC_ST_FAULT  = 5'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  op;
  logic [31:0] addr, wdata;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] rdata, rdata_nxt;
  logic [4:0]  exc, exc_nxt;
  logic [3:0]  be;
  logic [31:0] wrep, shifted, ld_val;

  function automatic logic op_legal(input logic [3:0] o);
    case (o)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_NOP: op_legal = 1'b1;
      default:                     op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] o, input logic [1:0] a);
    case (o)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  // op[1:0] encodes access size (byte/half/word), op[2] unsigned, op[3] store
  always_comb begin
    case (op[1:0])
      2'b00:   be = 4'b0001 << addr[1:0];
      2'b01:   be = 4'b0011 << addr[1:0];
      default: be = 4'b1111;
    endcase
    case (op[1:0])
      2'b00:   wrep = {4{wdata[7:0]}};
      2'b01:   wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
    shifted = bus_rdata_i >> {addr[1:0], 3'b000};
    case (op[2:0])
      3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_val = {24'd0, shifted[7:0]};
      3'b101:  ld_val = {16'd0, shifted[15:0]};
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;
    exc_nxt   = exc;
    case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (!op_legal(mem_oper_i)) begin
            exc_nxt   = EXC_ILL_INSTR;
            rdata_nxt = '0;
            state_nxt = S_RESP;
          end else if (mem_oper_i == OP_NOP) begin
            exc_nxt   = EXC_NO_TRAP;
            rdata_nxt = '0;
            state_nxt = S_RESP;
          end else if (misaligned(mem_oper_i, addr_i[1:0])) begin
            exc_nxt   = mem_oper_i[3] ? EXC_ST_MISAL : EXC_LD_MISAL;
            rdata_nxt = '0;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response arriving on the timeout cycle still wins
        if (bus_rvalid_i) begin
          state_nxt = S_RESP;
          if (bus_err_i) begin
            exc_nxt   = op[3] ? EXC_ST_FAULT : EXC_LD_FAULT;
            rdata_nxt = '0;
          end else begin
            exc_nxt   = EXC_NO_TRAP;
            rdata_nxt = op[3] ? 32'd0 : ld_val;
          end
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          exc_nxt   = op[3] ? EXC_ST_FAULT : EXC_LD_FAULT;
          rdata_nxt = '0;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= '0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      exc   <= EXC_NO_TRAP;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdata <= rdata_nxt;
      exc   <= exc_nxt;
      if (state == S_IDLE && req_valid_i) begin
        op    <= mem_oper_i;
        addr  <= addr_i;
        wdata <= wdata_i;
      end
    end
  end

  assign req_ready_o = (state == S_IDLE);
  assign done_o      = (state == S_RESP);
  assign rdata_o     = rdata;
  assign exc_o       = exc;
  assign bus_req_o   = (state == S_REQ);
  assign bus_addr_o  = bus_req_o ? {addr[31:2], 2'b00} : 32'd0;
  assign bus_we_o    = bus_req_o & op[3];
  assign bus_be_o    = bus_req_o ? be : 4'd0;
  assign bus_wdata_o = (bus_req_o && op[3]) ? wrep : 32'd0;

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, is the number of WAIT cycles without bus_rvalid_i before the access is declared faulted; legal range is 2..255.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 req_valid_i  input  1  pipeline presents a memory operation.
REQ-005 req_ready_o  output  1  operation accepted this cycle.
REQ-006 mem_oper_i  input  4  operation code; values are the shared mem_oper_t encoding (LB/LH/LW/LBU/LHU/SB/SH/SW/NOP).
REQ-007 addr_i  input  32  byte address.
REQ-008 wdata_i  input  32  store data, right-aligned.
REQ-009 done_o  output  1  one-cycle pulse; rdata_o and exc_o are valid in that cycle.
REQ-010 rdata_o  output  32  aligned, sign- or zero-extended load result.
REQ-011 exc_o  output  5  exc_t code; NO_TRAP is 5'b10000.
REQ-012 bus_req_o  output  1  bus request.
REQ-013 bus_gnt_i  input  1  bus grant.
REQ-014 bus_addr_o  output  32  word address, {addr[31:2],2'b00}.
REQ-015 bus_we_o  output  1  1 = write.
REQ-016 bus_be_o  output  4  byte enables.
REQ-017 bus_wdata_o  output  32  lane-replicated store data.
REQ-018 bus_rvalid_i  input  1  response valid.
REQ-019 bus_rdata_i  input  32  response data.
REQ-020 bus_err_i  input  1  response error; sampled only with bus_rvalid_i.

Function
REQ-021 FSM states are IDLE, REQ, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-022 IDLE, req_valid_i=1: capture operands, then go to RESP directly if the op is MEM_NOP, illegal, or misaligned; otherwise go to REQ.
REQ-023 Illegal codes (0011, 0110, 0111, 1011-1110) SHALL give exc ILL_INSTR (5'd2) and no bus request.
REQ-024 Misalignment means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
REQ-025 A misaligned load SHALL give LOAD_ADDR_MISALIGNED (5'd4); a misaligned store SHALL give STORE_AMO_ADDR_MISALIGNED (5'd6); neither SHALL issue a bus request.
REQ-026 REQ: bus_req_o=1; bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o SHALL be held stable until bus_gnt_i=1, then go to WAIT with the timeout counter cleared.
REQ-027 Byte enables: byte ops use 4'b0001<<addr[1:0]; half ops use 4'b0011<<addr[1:0]; word ops use 4'b1111. Loads use the same enables with bus_we_o=0.
REQ-028 Store data SHALL be replicated as SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-029 In WAIT, bus_rvalid_i=1 SHALL capture bus_rdata_i and set exc to NO_TRAP, or to LOAD_ACC_FAULT (5'd5) / STORE_AMO_ACC_FAULT (5'd7) if bus_err_i=1; then go to RESP.
REQ-030 In WAIT, the counter increments every cycle; when it reaches TIMEOUT-1 with no rvalid, the access fault code for the op type is set and the FSM goes to RESP.
REQ-031 If rvalid and timeout occur in the same cycle, rvalid SHALL take priority.
REQ-032 RESP: done_o=1 for exactly one cycle, then go to IDLE.
REQ-033 Load data SHALL be shifted right by addr[1:0]*8, then LB/LH sign-extended and LBU/LHU zero-extended.
REQ-034 rdata_o SHALL be 0 for stores, NOP, and any faulted access.
REQ-035 Minimum latency with gnt on the first REQ cycle and rvalid on the next cycle: accept at N, done_o at N+3.
REQ-036 Minimum latency for a non-bus op (NOP, illegal, misaligned): accept at N, done_o at N+1.
REQ-037 bus_rvalid_i outside WAIT (including rvalid in the same cycle as bus_gnt_i) SHALL be ignored.
REQ-038 bus_gnt_i outside REQ SHALL be ignored.
REQ-039 bus_req_o SHALL never be asserted outside REQ.

Reset
REQ-040 While rst_i=1, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-041 Reset values: done_o=0, rdata_o=0, exc_o=NO_TRAP, req_ready_o=1, and all bus outputs 0.
REQ-042 Reset in any state aborts the access: bus_req_o is low the cycle after rst_i is sampled, and a late rvalid SHALL produce no done_o.

Verification
REQ-043 LB at 0x00001003, bus_rdata_i=0x80AABBCC -> bus_addr_o 0x00001000, bus_be_o 4'b1000, rdata_o 0xFFFFFF80, exc_o 5'b10000.
REQ-044 SH at 0x00002002, wdata_i 0x0000BEEF, gnt delayed 3 cycles -> bus_be_o 4'b1100, bus_wdata_o 0xBEEFBEEF, bus_we_o=1, outputs stable across the wait, done_o with NO_TRAP.
REQ-045 LW at 0x00003001 -> bus_req_o never asserted, done_o on the next cycle, exc_o 5'd4, rdata_o 0.
REQ-046 LHU at 0x00004000 with gnt but no rvalid (TIMEOUT=64) -> done_o after 64 WAIT cycles with exc_o 5'd5.
REQ-047 SW granted, rvalid with bus_err_i=1 -> exc_o 5'd7; a second trial with rvalid on exactly the timeout cycle -> NO_TRAP.
REQ-048 rst_i pulsed during WAIT, rvalid driven 2 cycles later -> no done_o, req_ready_o=1, outputs at their reset values.
